// File: rtl/lsu_return_align_pkg.sv
// Shared types for the LSU load-return path: config widths, size encoding, slot layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lsu_return_align_pkg;

    localparam int XLEN         = 64;
    localparam int CACHE_USER_W = 4;
    localparam int ID_W         = 8;
    localparam int ERR_W        = 6;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    // Written at issue time.
    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [3:0]      offset;
        logic [1:0]      size;
        logic            sgn;
    } slot_meta_t;

    // Written at return time; rdata is kept raw and aligned on the way out.
    typedef struct packed {
        logic [2*XLEN-1:0]       rdata;
        logic [CACHE_USER_W-1:0] user;
        logic [ERR_W-1:0]        error;
        logic                    mmio;
    } slot_pay_t;

endpackage

// File: rtl/lsu_return_align_load_data_align.sv
// Combinational load aligner: picks the 64-bit half, shifts by byte offset, truncates and extends.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: rdata_i raw 128-bit beat, offset_i/size_i/signed_i from the request,
//        error_i forces the result to zero, data_o aligned XLEN result.
module load_data_align
    import lsu_return_align_pkg::*;
(
    input  logic [2*XLEN-1:0] rdata_i,
    input  logic [3:0]        offset_i,
    input  logic [1:0]        size_i,
    input  logic              signed_i,
    input  logic [ERR_W-1:0]  error_i,
    output logic [XLEN-1:0]   data_o
);

    logic [XLEN-1:0] half;
    logic [XLEN-1:0] shifted;

    assign half    = offset_i[3] ? rdata_i[2*XLEN-1:XLEN] : rdata_i[XLEN-1:0];
    // Zero fill from the top: accesses that run past the half are silently truncated.
    assign shifted = half >> {offset_i[2:0], 3'b000};

    always_comb begin
        data_o = shifted;
        case (size_e'(size_i))
            SZ_BYTE:  data_o = {{(XLEN-8){signed_i & shifted[7]}},   shifted[7:0]};
            SZ_HALF:  data_o = {{(XLEN-16){signed_i & shifted[15]}}, shifted[15:0]};
            SZ_WORD:  data_o = {{(XLEN-32){signed_i & shifted[31]}}, shifted[31:0]};
            default:  data_o = shifted;
        endcase
        if (error_i != '0) begin
            data_o = '0;
        end
    end

endmodule

// File: rtl/lsu_return_align.sv
// Tracks outstanding loads in order, captures cache returns, presents aligned results for writeback.
// Latency: a return is visible on wb_* the cycle after ret_valid_i.
// Backpressure: wb_ready_i stalls the head (outputs held); can_issue_o drops when all slots are in use.
// Ports: clk_i/srst_i clock and sync reset; iss_* request issue; ret_* cache return (no ready);
//        wb_* aligned result with valid/ready; proto_err_o sticky violation flag.
module lsu_return_align
    import lsu_return_align_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    srst_i,
    input  logic                    iss_valid_i,
    input  logic [ID_W-1:0]         iss_id_i,
    input  logic [3:0]              iss_offset_i,
    input  logic [1:0]              iss_size_i,
    input  logic                    iss_signed_i,
    output logic                    can_issue_o,
    input  logic                    ret_valid_i,
    input  logic [2*XLEN-1:0]       ret_rdata_i,
    input  logic [ID_W-1:0]         ret_id_i,
    input  logic [CACHE_USER_W-1:0] ret_user_i,
    input  logic [ERR_W-1:0]        ret_error_i,
    input  logic                    ret_mmio_i,
    output logic                    wb_valid_o,
    input  logic                    wb_ready_i,
    output logic [XLEN-1:0]         wb_data_o,
    output logic [ID_W-1:0]         wb_id_o,
    output logic [CACHE_USER_W-1:0] wb_user_o,
    output logic [ERR_W-1:0]        wb_error_o,
    output logic                    wb_mmio_o,
    output logic                    proto_err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] wr_q, wr_d, fl_q, fl_d, rd_q, rd_d;
    logic          perr_q, perr_d;

    slot_meta_t meta_q [DEPTH];
    slot_pay_t  pay_q  [DEPTH];

    logic [PW-1:0] occ;
    logic          pending;
    logic          iss_fire, ret_fire, wb_fire;
    logic          id_mismatch;

    slot_meta_t head_meta;
    slot_pay_t  head_pay;

    assign occ         = wr_q - rd_q;
    assign can_issue_o = occ < PW'(DEPTH);
    assign pending     = fl_q != wr_q;
    assign wb_valid_o  = rd_q != fl_q;

    assign iss_fire    = iss_valid_i & can_issue_o;
    assign ret_fire    = ret_valid_i & pending;
    assign wb_fire     = wb_valid_o & wb_ready_i;
    assign id_mismatch = ret_fire & (ret_id_i != meta_q[fl_q[AW-1:0]].id);

    always_comb begin
        wr_d   = wr_q + PW'(iss_fire);
        fl_d   = fl_q + PW'(ret_fire);
        rd_d   = rd_q + PW'(wb_fire);
        perr_d = perr_q
               | (iss_valid_i & ~can_issue_o)
               | (ret_valid_i & ~pending)
               | id_mismatch;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_q   <= '0;
            fl_q   <= '0;
            rd_q   <= '0;
            perr_q <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            fl_q   <= fl_d;
            rd_q   <= rd_d;
            perr_q <= perr_d;
        end
    end

    // Slot storage is not reset; occupancy is defined purely by the pointers.
    always_ff @(posedge clk_i) begin
        if (!srst_i && iss_fire) begin
            meta_q[wr_q[AW-1:0]] <= '{id: iss_id_i, offset: iss_offset_i,
                                      size: iss_size_i, sgn: iss_signed_i};
        end
        if (!srst_i && ret_fire) begin
            pay_q[fl_q[AW-1:0]] <= '{rdata: ret_rdata_i, user: ret_user_i,
                                     error: ret_error_i, mmio: ret_mmio_i};
        end
    end

    assign head_meta   = meta_q[rd_q[AW-1:0]];
    assign head_pay    = pay_q[rd_q[AW-1:0]];
    assign proto_err_o = perr_q;
    assign wb_id_o     = head_meta.id;
    assign wb_user_o   = head_pay.user;
    assign wb_error_o  = head_pay.error;
    assign wb_mmio_o   = head_pay.mmio;

    load_data_align u_align (
        .rdata_i  (head_pay.rdata),
        .offset_i (head_meta.offset),
        .size_i   (head_meta.size),
        .signed_i (head_meta.sgn),
        .error_i  (head_pay.error),
        .data_o   (wb_data_o)
    );

endmodule

// File: tb/tb_lsu_return_align.sv
module tb_lsu_return_align;

    logic         clk_i = 1'b0;
    logic         srst_i;
    logic         iss_valid_i;
    logic [7:0]   iss_id_i;
    logic [3:0]   iss_offset_i;
    logic [1:0]   iss_size_i;
    logic         iss_signed_i;
    logic         can_issue_o;
    logic         ret_valid_i;
    logic [127:0] ret_rdata_i;
    logic [7:0]   ret_id_i;
    logic [3:0]   ret_user_i;
    logic [5:0]   ret_error_i;
    logic         ret_mmio_i;
    logic         wb_valid_o;
    logic         wb_ready_i;
    logic [63:0]  wb_data_o;
    logic [7:0]   wb_id_o;
    logic [3:0]   wb_user_o;
    logic [5:0]   wb_error_o;
    logic         wb_mmio_o;
    logic         proto_err_o;

    localparam int DEPTH = 4;

    always #5 clk_i = ~clk_i;

    lsu_return_align #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .srst_i(srst_i),
        .iss_valid_i(iss_valid_i), .iss_id_i(iss_id_i), .iss_offset_i(iss_offset_i),
        .iss_size_i(iss_size_i), .iss_signed_i(iss_signed_i), .can_issue_o(can_issue_o),
        .ret_valid_i(ret_valid_i), .ret_rdata_i(ret_rdata_i), .ret_id_i(ret_id_i),
        .ret_user_i(ret_user_i), .ret_error_i(ret_error_i), .ret_mmio_i(ret_mmio_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
        .wb_id_o(wb_id_o), .wb_user_o(wb_user_o), .wb_error_o(wb_error_o),
        .wb_mmio_o(wb_mmio_o), .proto_err_o(proto_err_o)
    );

    typedef struct {
        logic [7:0] id;
        logic [3:0] off;
        logic [1:0] sz;
        logic       sg;
    } meta_t;

    typedef struct {
        logic [7:0]  id;
        logic [63:0] data;
        logic [3:0]  user;
        logic [5:0]  err;
        logic        mmio;
    } exp_t;

    meta_t pend[$];
    exp_t  sb[$];
    logic  exp_perr;
    int    n_vec = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Byte-wise reference: take the bytes the access covers, stop at the end of the
    // selected 64-bit half, then extend from the top bit of the access width.
    function automatic logic [63:0] model_align(input logic [127:0] rd, input meta_t m,
                                                input logic [5:0] err);
        logic [63:0] r;
        int nb, base, st;
        r = '0;
        if (err != 0) return r;
        nb   = 1 << m.sz;
        base = m.off[3] ? 8 : 0;
        st   = int'(m.off[2:0]);
        for (int i = 0; i < nb; i++)
            if (st + i < 8) r[i*8 +: 8] = rd[(base + st + i)*8 +: 8];
        if (m.sg && r[nb*8-1])
            for (int b = nb*8; b < 64; b++) r[b] = 1'b1;
        return r;
    endfunction

    // Scoreboard consumer: compares each accepted result at the negedge before the handshake edge.
    always @(negedge clk_i) begin
        if (!srst_i && wb_valid_o && wb_ready_i) begin
            if (sb.size() == 0) begin
                chk("spurious_wb", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_id",    wb_id_o,    e.id);
                chk("wb_data",  wb_data_o,  e.data);
                chk("wb_user",  wb_user_o,  e.user);
                chk("wb_error", wb_error_o, e.err);
                chk("wb_mmio",  wb_mmio_o,  e.mmio);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cyc(input logic iv, input logic [7:0] id, input logic [3:0] off,
                       input logic [1:0] sz, input logic sg,
                       input logic rv, input logic [127:0] rdata, input logic [7:0] rid,
                       input logic [3:0] ru, input logic [5:0] re, input logic rm,
                       input logic rdy);
        logic  mcan;
        meta_t m;
        exp_t  e;
        mcan = (pend.size() + sb.size()) < DEPTH;
        chk("can_issue", can_issue_o, mcan);
        if (rv) begin
            if (pend.size() > 0) begin
                m = pend.pop_front();
                if (rid != m.id) exp_perr = 1'b1;
                e.id = m.id; e.data = model_align(rdata, m, re);
                e.user = ru; e.err = re; e.mmio = rm;
                sb.push_back(e);
            end else begin
                exp_perr = 1'b1;
            end
        end
        if (iv) begin
            if (mcan) begin
                m.id = id; m.off = off; m.sz = sz; m.sg = sg;
                pend.push_back(m);
            end else begin
                exp_perr = 1'b1;
            end
        end
        iss_valid_i = iv; iss_id_i = id; iss_offset_i = off; iss_size_i = sz; iss_signed_i = sg;
        ret_valid_i = rv; ret_rdata_i = rdata; ret_id_i = rid; ret_user_i = ru;
        ret_error_i = re; ret_mmio_i = rm; wb_ready_i = rdy;
        tick();
        iss_valid_i = 1'b0;
        ret_valid_i = 1'b0;
        chk("proto_err", proto_err_o, exp_perr);
        chk("wb_valid",  wb_valid_o,  sb.size() != 0);
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 8'h0, 4'h0, 2'd0, 1'b0, 1'b0, '0, 8'h0, 4'h0, 6'h0, 1'b0, rdy);
    endtask

    task automatic issue(input logic [7:0] id, input logic [3:0] off, input logic [1:0] sz,
                         input logic sg, input logic rdy);
        cyc(1'b1, id, off, sz, sg, 1'b0, '0, 8'h0, 4'h0, 6'h0, 1'b0, rdy);
    endtask

    task automatic ret(input logic [127:0] rdata, input logic [3:0] ru, input logic [5:0] re,
                       input logic rm, input logic rdy);
        logic [7:0] rid;
        rid = (pend.size() > 0) ? pend[0].id : 8'h00;
        cyc(1'b0, 8'h0, 4'h0, 2'd0, 1'b0, 1'b1, rdata, rid, ru, re, rm, rdy);
    endtask

    // A return and an issue are presented during reset; both must be discarded.
    task automatic do_reset();
        srst_i = 1'b1;
        iss_valid_i = 1'b1; iss_id_i = 8'hEE;
        ret_valid_i = 1'b1; ret_rdata_i = '1; ret_id_i = 8'hEE; wb_ready_i = 1'b0;
        pend.delete(); sb.delete(); exp_perr = 1'b0;
        tick();
        tick();
        srst_i = 1'b0; iss_valid_i = 1'b0; ret_valid_i = 1'b0;
        chk("rst_wb_valid",  wb_valid_o,  1'b0);
        chk("rst_can_issue", can_issue_o, 1'b1);
        chk("rst_proto_err", proto_err_o, 1'b0);
    endtask

    initial begin
        logic [127:0] rd;
        logic [63:0]  first_data;
        srst_i = 1'b0; iss_valid_i = 1'b0; iss_id_i = '0; iss_offset_i = '0; iss_size_i = '0;
        iss_signed_i = 1'b0; ret_valid_i = 1'b0; ret_rdata_i = '0; ret_id_i = '0;
        ret_user_i = '0; ret_error_i = '0; ret_mmio_i = 1'b0; wb_ready_i = 1'b0; exp_perr = 1'b0;
        tick();
        do_reset();

        // Signed half at byte 9 lives in rdata[87:72].
        issue(8'h05, 4'h9, 2'd1, 1'b1, 1'b0);
        rd = '0; rd[87:72] = 16'h8001;
        ret(rd, 4'h3, 6'h0, 1'b0, 1'b0);
        chk("half_s_valid", wb_valid_o, 1'b1);
        chk("half_s_data",  wb_data_o,  64'hFFFF_FFFF_FFFF_8001);
        chk("half_s_id",    wb_id_o,    8'h05);
        idle(1'b1);

        // Unsigned half at byte 8 (rdata[79:64]), signed word at byte 4, dword truncated at byte 15.
        issue(8'h10, 4'h8, 2'd1, 1'b0, 1'b1);
        rd = '0; rd[79:64] = 16'h8001;
        ret(rd, 4'h0, 6'h0, 1'b0, 1'b0);
        chk("half_u_data", wb_data_o, 64'h0000_0000_0000_8001);
        idle(1'b1);
        issue(8'h11, 4'h4, 2'd2, 1'b1, 1'b0);
        rd = '0; rd[63:32] = 32'h8000_0000;
        ret(rd, 4'h0, 6'h0, 1'b0, 1'b0);
        chk("word_s_data", wb_data_o, 64'hFFFF_FFFF_8000_0000);
        idle(1'b1);
        issue(8'h12, 4'hF, 2'd3, 1'b1, 1'b0);
        rd = '1; rd[127:120] = 8'hF0;
        ret(rd, 4'h0, 6'h0, 1'b0, 1'b0);
        chk("dword_trunc", wb_data_o, 64'h0000_0000_0000_00F0);
        idle(1'b1);

        // Fill all slots, overflow issue, then stall four returns and drain in order.
        for (int i = 0; i < 4; i++) issue(8'h20 + 8'(i), 4'(i*3), 2'(i), i[0], 1'b0);
        chk("full_can_issue", can_issue_o, 1'b0);
        issue(8'h99, 4'h0, 2'd0, 1'b0, 1'b0);
        chk("overflow_perr", proto_err_o, 1'b1);
        for (int i = 0; i < 4; i++) ret({4{$urandom}}, 4'(i), 6'h0, 1'b0, 1'b0);
        first_data = sb[0].data;
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            chk("stall_id",   wb_id_o,   8'h20);
            chk("stall_data", wb_data_o, first_data);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("drained", wb_valid_o, 1'b0);

        // Return with nothing outstanding.
        do_reset();
        ret(128'h1234, 4'h0, 6'h0, 1'b0, 1'b1);
        chk("drop_valid", wb_valid_o,  1'b0);
        chk("drop_perr",  proto_err_o, 1'b1);

        // Error return forces data to zero and passes error/mmio through.
        do_reset();
        issue(8'h33, 4'h0, 2'd3, 1'b0, 1'b0);
        ret('1, 4'hA, 6'h01, 1'b1, 1'b0);
        chk("err_data", wb_data_o,  64'h0);
        chk("err_code", wb_error_o, 6'h01);
        chk("err_mmio", wb_mmio_o,  1'b1);
        chk("err_user", wb_user_o,  4'hA);
        idle(1'b1);

        // Returned id differs from the stored one: slot still fills, stored id reported.
        cyc(1'b1, 8'h44, 4'h0, 2'd2, 1'b0, 1'b0, '0, 8'h0, 4'h0, 6'h0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 4'h0, 2'd0, 1'b0, 1'b1, 128'hCAFE_F00D, 8'h45, 4'h0, 6'h0, 1'b0, 1'b0);
        chk("mism_id", wb_id_o, 8'h44);
        idle(1'b1);

        // Mid-operation reset with 2 pending and 1 filled.
        do_reset();
        for (int i = 0; i < 3; i++) issue(8'h50 + 8'(i), 4'h0, 2'd0, 1'b0, 1'b0);
        ret(128'h77, 4'h0, 6'h0, 1'b0, 1'b0);
        do_reset();

        // Full buffer with simultaneous pop and issue: the issue is rejected this cycle.
        for (int i = 0; i < 4; i++) issue(8'h60 + 8'(i), 4'h0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ret({4{$urandom}}, 4'h0, 6'h0, 1'b0, 1'b0);
        issue(8'h70, 4'h0, 2'd0, 1'b0, 1'b1);
        issue(8'h71, 4'h1, 2'd1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) idle(1'b1);
        ret({4{$urandom}}, 4'h2, 6'h0, 1'b0, 1'b1);
        idle(1'b1);

        // Random traffic with concurrent issue, return and pop.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic       iv, rv;
            logic [7:0] rid;
            iv  = ($urandom_range(0, 1) == 1);
            rv  = (pend.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 19) == 0);
            rid = (pend.size() > 0) ? pend[0].id : 8'h00;
            if ($urandom_range(0, 15) == 0) rid = rid ^ 8'h01;
            cyc(iv, 8'($urandom), 4'($urandom), 2'($urandom), 1'($urandom),
                rv, {$urandom, $urandom, $urandom, $urandom}, rid, 4'($urandom),
                ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'h0,
                1'($urandom), ($urandom_range(0, 3) != 0));
        end
        for (int c = 0; c < 20 && (pend.size() > 0 || sb.size() > 0); c++) begin
            if (pend.size() > 0) ret({4{$urandom}}, 4'h1, 6'h0, 1'b0, 1'b1);
            else idle(1'b1);
        end
        chk("final_empty", (pend.size() == 0 && sb.size() == 0), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
